bch_chien_par: RTL and testbench
================================

// Module: bch_chien_par
// PURPOSE
//  P-way parallel Chien search for the hard-decision BCH path. Takes the error-locator
//  sigma(x) from Berlekamp and marks bit i of the codeword erroneous iff sigma(alpha^-i)=0.
//  Supports shortened codes (n < 2^m-1) and runtime field select m = 6/8/10.
//  Outputs error vector, root count and success.
//  Replaces the serial Chien stage of the hard-decision core; the core gates success on it.
// PARAMETERS
//  N_MAX      1023  max codeword length; width of err_vec
//  T_MAX      4     max correctable errors; sigma holds T_MAX+1 coefficients
//  M_MAX      10    GF width; coefficient width in sigma
//  P          8     roots evaluated per cycle (1..16)
//  EARLY_STOP 1     1: end search once root count == sigma_deg
// PORTS
//  clk        in   1                  clock, rising edge
//  rstn       in   1                  async active-low reset
//  start      in   1                  1-cycle request; sampled only in IDLE
//  n          in   10                 code length; 1..2^m-1, <= N_MAX
//  t          in   4                  code capability; 1..T_MAX
//  m          in   4                  field: 6, 8 or 10
//  sigma      in   (T_MAX+1)*M_MAX    coef j at [j*M_MAX +: M_MAX]; LSB-aligned in m bits
//  sigma_deg  in   4                  degree reported by Berlekamp
//  busy       out  1                  high from start accept until done
//  done       out  1                  1-cycle pulse; result outputs valid from this cycle
//  success    out  1                  decode accepted
//  err_cnt    out  4                  roots found; saturates at 15
//  err_vec    out  N_MAX              bit i = 1: codeword bit i in error
// BEHAVIOUR
//  Reset: state IDLE; busy/done/success = 0; err_cnt = 0; err_vec = 0.
//  Primitive polynomials: m=6 0x43, m=8 0x11D, m=10 0x409.
//  Coefficient bits above m are ignored.
//  FSM:
//   IDLE->LOAD on start.
//   LOAD (1 cyc):
//    - latch n, t, m, sigma_deg.
//    - reg_j <= sigma_j; clear err_vec and err_cnt.
//    - Check config. cfg_err = (m not in {6,8,10}) | n==0 | n>2^m-1 | n>N_MAX
//      | t==0 | t>T_MAX | sigma_deg>t | sigma_0==0.
//    - cfg_err -> DONE with success = 0.
//    - else sigma_deg==0 -> DONE with success = 1.
//    - else -> SEARCH.
//   SEARCH (blk = 0..ceil(n/P)-1, one block per cycle):
//    - lane p tests i = blk*P+p.
//    - S_p = XOR_j reg_j * alpha^(-j*p), with constants per m.
//    - S_p==0 and i<n: set err_vec[i], err_cnt += 1 (saturating).
//    - Lanes with i>=n are masked.
//    - Then reg_j <= reg_j * alpha^(-j*P).
//    - Leave after last block, or early when EARLY_STOP and count reaches sigma_deg.
//   DONE (1 cyc):
//    - done=1, busy=0, success = (err_cnt == sigma_deg). Then IDLE.
//    - success, err_cnt and err_vec hold until the next start is accepted.
//  Timing (start sampled at edge 0):
//   - done=1 in the cycle after edge 2+B, where B = ceil(n/P) full search.
//   - Skipped search (cfg_err or deg 0): done after edge 2.
//   - EARLY_STOP: done at or before full-search timing.
//  Edge rules:
//   - start while busy: ignored.
//   - start in the DONE cycle: ignored.
//   - Inputs may change after the LOAD edge without effect.
//   - rstn low mid-search: immediate clear to reset values; no done.
//   - err_cnt > sigma_deg (wrong degree report): success = 0.
//   - Constant multipliers are XOR networks selected by latched m; no lookup RAMs.
// TESTING
//  T1 m=6 n=63 t=2 P=8; sigma_0=1, sigma_1=0x20 (a^5), deg=1
//     -> done 10 cyc after start, success=1, err_cnt=1, err_vec=1<<5.
//  T2 m=6 n=63 t=2; sigma=(1,0x20,0x21), deg=2
//     -> success=1, err_cnt=2, err_vec bits 0 and 62 only.
//  T3 sigma_1=0x20, sigma_2=0, deg=2 -> success=0, err_cnt=1, err_vec=1<<5.
//  T4 m=6 t=2 deg=3 -> done 2 cyc after start, success=0, err_vec=0.
//     Also n=64 -> same result.
//  T5 m=8 n=255 t=4; sigma_1=0x8E (a^-1), deg=1
//     -> success=1, err_vec=1<<254, full-search timing.
//     Shortened n=100 -> success=0, err_vec=0 (root masked).
//  T6 rstn low mid-SEARCH of T2 -> all outputs 0 immediately.
//     Re-run T1 -> correct result. Extra start pulses during busy are ignored.

Source files
------------

// File: rtl/bch_chien_par.sv
// bch_chien_par: P-way parallel Chien search over GF(2^m), m = 6/8/10, for shortened BCH codes.
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start_i         one-cycle request, accepted only when idle
//   n_i, t_i, m_i   code length, capability and field width of the request
//   sigma_i         error locator; coefficient j at [j*M_MAX +: M_MAX]
//   sigma_deg_i     locator degree reported by Berlekamp
//   busy_o          high from start accept until done
//   done_o          one-cycle pulse; results valid from this cycle
//   success_o       root count matched the degree and config was legal
//   err_cnt_o       roots found, saturating at 15
//   err_vec_o       bit i set when codeword bit i is in error
module bch_chien_par #(
  parameter int N_MAX      = 1023,
  parameter int T_MAX      = 4,
  parameter int M_MAX      = 10,
  parameter int P          = 8,
  parameter int EARLY_STOP = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [9:0]                 n_i,
  input  logic [3:0]                 t_i,
  input  logic [3:0]                 m_i,
  input  logic [(T_MAX+1)*M_MAX-1:0] sigma_i,
  input  logic [3:0]                 sigma_deg_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       success_o,
  output logic [3:0]                 err_cnt_o,
  output logic [N_MAX-1:0]           err_vec_o
);
  localparam int IW = 11;
  localparam logic [9:0] L6  = 10'(N_MAX < 63 ? N_MAX : 63);
  localparam logic [9:0] L8  = 10'(N_MAX < 255 ? N_MAX : 255);
  localparam logic [9:0] L10 = 10'(N_MAX < 1023 ? N_MAX : 1023);

  // Shift-and-add multiply in GF(2^mm); with a constant operand this folds to an XOR network.
  function automatic logic [M_MAX-1:0] gf_mul(input logic [M_MAX-1:0] a, input logic [M_MAX-1:0] b, input int mm);
    logic [M_MAX-1:0] r, x, msk, low;
    logic c;
    msk = M_MAX'((1 << mm) - 1);
    low = mm == 6 ? M_MAX'(10'h003) : mm == 8 ? M_MAX'(10'h01D) : M_MAX'(10'h009);
    r = '0;
    x = a & msk;
    for (int k = 0; k < M_MAX; k++) begin
      if (k < mm && (b & (M_MAX'(1) << k)) != '0) r = r ^ x;
      c = (x & (M_MAX'(1) << (mm - 1))) != '0;
      x = ((x << 1) & msk) ^ (c ? low : '0);
    end
    return r;
  endfunction

  function automatic logic [M_MAX-1:0] gf_pow(input int e, input int mm);
    logic [M_MAX-1:0] r, b;
    r = M_MAX'(1);
    b = M_MAX'(2);
    for (int k = 0; k < 16; k++) begin
      if (((e >> k) & 1) != 0) r = gf_mul(r, b, mm);
      b = gf_mul(b, b, mm);
    end
    return r;
  endfunction

  // Exponent of alpha^-e, reduced into 0..2^mm-2.
  function automatic int nexp(input int e, input int mm);
    int q;
    q = (1 << mm) - 1;
    return (q - e % q) % q;
  endfunction

  typedef enum logic [1:0] {IDLE, LOAD, SEARCH, DONE} state_t;

  state_t             state_q;
  logic               busy_q, done_q, succ_q, fail_q;
  logic [3:0]         cnt_q, deg_q, cnt_d;
  logic [9:0]         n_q, lim;
  logic [1:0]         msel_q, msel_i;
  logic [IW-1:0]      base_q;
  logic [N_MAX-1:0]   vec_q, vec_d;
  logic [M_MAX-1:0]   reg_q [T_MAX+1];
  logic [M_MAX-1:0]   nxt   [T_MAX+1];
  logic [M_MAX-1:0]   term  [P][T_MAX+1];
  logic [M_MAX-1:0]   msk_i, s;
  logic [P-1:0]       hit;
  logic [4:0]         pop;
  logic [5:0]         sum;
  logic               last, stop, cfg_err;

  // msel: 0 -> m=6, 1 -> m=8, 2 -> m=10
  assign msel_i  = m_i == 4'd6 ? 2'd0 : m_i == 4'd8 ? 2'd1 : 2'd2;
  assign msk_i   = M_MAX'(m_i == 4'd6 ? 10'h03F : m_i == 4'd8 ? 10'h0FF : 10'h3FF);
  assign lim     = m_i == 4'd6 ? L6 : m_i == 4'd8 ? L8 : L10;
  assign cfg_err = !(m_i == 4'd6 || m_i == 4'd8 || m_i == 4'd10) || n_i == 10'd0 || n_i > lim ||
                   t_i == 4'd0 || t_i > 4'(T_MAX) || sigma_deg_i > t_i ||
                   (sigma_i[M_MAX-1:0] & msk_i) == '0;

  for (genvar p = 0; p < P; p++) begin : g_lane
    for (genvar j = 0; j <= T_MAX; j++) begin : g_term
      localparam logic [M_MAX-1:0] C6  = gf_pow(nexp(j * p, 6), 6);
      localparam logic [M_MAX-1:0] C8  = gf_pow(nexp(j * p, 8), 8);
      localparam logic [M_MAX-1:0] C10 = gf_pow(nexp(j * p, 10), 10);
      assign term[p][j] = msel_q == 2'd0 ? gf_mul(reg_q[j], C6, 6) :
                          msel_q == 2'd1 ? gf_mul(reg_q[j], C8, 8) : gf_mul(reg_q[j], C10, 10);
    end
  end

  // Advance every coefficient by one block: reg_j *= alpha^(-j*P).
  for (genvar j = 0; j <= T_MAX; j++) begin : g_step
    localparam logic [M_MAX-1:0] D6  = gf_pow(nexp(j * P, 6), 6);
    localparam logic [M_MAX-1:0] D8  = gf_pow(nexp(j * P, 8), 8);
    localparam logic [M_MAX-1:0] D10 = gf_pow(nexp(j * P, 10), 10);
    assign nxt[j] = msel_q == 2'd0 ? gf_mul(reg_q[j], D6, 6) :
                    msel_q == 2'd1 ? gf_mul(reg_q[j], D8, 8) : gf_mul(reg_q[j], D10, 10);
  end

  always_comb begin
    hit = '0;
    s   = '0;
    pop = '0;
    for (int p = 0; p < P; p++) begin
      s = '0;
      for (int j = 0; j <= T_MAX; j++) s = s ^ term[p][j];
      hit[p] = s == '0 && (base_q + IW'(p)) < IW'(n_q);
      pop = pop + 5'(hit[p]);
    end
    sum   = 6'(cnt_q) + 6'(pop);
    cnt_d = sum > 6'd15 ? 4'd15 : sum[3:0];
    vec_d = vec_q | (N_MAX'(hit) << base_q);
    last  = (base_q + IW'(P)) >= IW'(n_q);
    stop  = last || (EARLY_STOP != 0 && cnt_d >= deg_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      succ_q  <= 1'b0;
      fail_q  <= 1'b0;
      cnt_q   <= '0;
      deg_q   <= '0;
      n_q     <= '0;
      msel_q  <= '0;
      base_q  <= '0;
      vec_q   <= '0;
      for (int j = 0; j <= T_MAX; j++) reg_q[j] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i && !done_q) begin
          state_q <= LOAD;
          busy_q  <= 1'b1;
          succ_q  <= 1'b0;
          cnt_q   <= '0;
          vec_q   <= '0;
        end
        LOAD: begin
          n_q     <= n_i;
          deg_q   <= sigma_deg_i;
          msel_q  <= msel_i;
          fail_q  <= cfg_err;
          base_q  <= '0;
          cnt_q   <= '0;
          vec_q   <= '0;
          for (int j = 0; j <= T_MAX; j++) reg_q[j] <= sigma_i[j*M_MAX +: M_MAX] & msk_i;
          state_q <= (cfg_err || sigma_deg_i == 4'd0) ? DONE : SEARCH;
        end
        SEARCH: begin
          cnt_q  <= cnt_d;
          vec_q  <= vec_d;
          base_q <= base_q + IW'(P);
          for (int j = 0; j <= T_MAX; j++) reg_q[j] <= nxt[j];
          if (stop) state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          succ_q  <= !fail_q && cnt_q == deg_q;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign success_o = succ_q;
  assign err_cnt_o = cnt_q;
  assign err_vec_o = vec_q;
endmodule

// File: tb/tb_bch_chien_par.sv
// tb_bch_chien_par: directed checks of the parallel Chien search (full-search and early-stop instances).
module tb_bch_chien_par;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [9:0]    n_i = '0;
  logic [3:0]    t_i = '0, m_i = '0, sigma_deg_i = '0;
  logic [49:0]   sigma_i = '0;
  logic          busy_o, done_o, success_o;
  logic [3:0]    err_cnt_o;
  logic [1022:0] err_vec_o;
  logic          es_busy, es_done, es_success;
  logic [3:0]    es_cnt;
  logic [1022:0] es_vec;
  logic [1022:0] ev;
  int            ncmp = 0, nerr = 0;
  int            lat, elat;

  always #5 clk = ~clk;

  bch_chien_par #(.N_MAX(1023), .T_MAX(4), .M_MAX(10), .P(8), .EARLY_STOP(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .n_i(n_i), .t_i(t_i), .m_i(m_i),
    .sigma_i(sigma_i), .sigma_deg_i(sigma_deg_i), .busy_o(busy_o), .done_o(done_o),
    .success_o(success_o), .err_cnt_o(err_cnt_o), .err_vec_o(err_vec_o));

  bch_chien_par #(.N_MAX(1023), .T_MAX(4), .M_MAX(10), .P(8), .EARLY_STOP(1)) u_es (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .n_i(n_i), .t_i(t_i), .m_i(m_i),
    .sigma_i(sigma_i), .sigma_deg_i(sigma_deg_i), .busy_o(es_busy), .done_o(es_done),
    .success_o(es_success), .err_cnt_o(es_cnt), .err_vec_o(es_vec));

  function automatic logic [49:0] pk(input logic [9:0] c0, input logic [9:0] c1, input logic [9:0] c2);
    return {20'h0, c2, c1, c0};
  endfunction

  function automatic logic [1022:0] bits(input int a, input int b);
    logic [1022:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    return v;
  endfunction

  // Launch one search; lat/elat = edge index (start edge = 0) after which done is first seen.
  task automatic run(input logic [9:0] n, input logic [3:0] t, input logic [3:0] m, input logic [3:0] deg,
                     input logic [49:0] sig, input bit scr, input bit poke, output int l, output int el);
    @(negedge clk);
    n_i = n; t_i = t; m_i = m; sigma_deg_i = deg; sigma_i = sig; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    l = 0;
    el = 0;
    for (int c = 1; c <= 2000 && l == 0; c++) begin
      @(negedge clk);
      if (scr && c == 1) begin
        sigma_i = 50'({$urandom, $urandom});
        n_i = 10'($urandom);
        t_i = 4'($urandom);
        m_i = 4'($urandom);
        sigma_deg_i = 4'($urandom);
      end
      if (poke) start_i = (c == 4);
      if (es_done && el == 0) el = c;
      if (done_o) l = c;
    end
    start_i = 1'b0;
    ncmp++;
    if (l == 0) begin nerr++; $display("FAIL run_timeout: no done within 2000 cycles"); end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ncmp++; if (busy_o !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    ncmp++; if (done_o !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b want 0", done_o); end
    ncmp++; if (success_o !== 1'b0) begin nerr++; $display("FAIL reset_success: got %b want 0", success_o); end
    ncmp++; if (err_cnt_o !== 4'd0) begin nerr++; $display("FAIL reset_cnt: got %0d want 0", err_cnt_o); end
    ncmp++; if (err_vec_o !== '0) begin nerr++; $display("FAIL reset_vec: nonzero error vector"); end
  endtask

  task automatic test_single;
    run(10'd63, 4'd2, 4'd6, 4'd1, pk(10'h001, 10'h020, 10'h000), 1'b0, 1'b0, lat, elat);
    ev = bits(5, -1);
    ncmp++; if (lat !== 10) begin nerr++; $display("FAIL t1_latency: got %0d want 10", lat); end
    ncmp++; if (busy_o !== 1'b0) begin nerr++; $display("FAIL t1_busy_at_done: got %b want 0", busy_o); end
    ncmp++; if (success_o !== 1'b1) begin nerr++; $display("FAIL t1_success: got %b want 1", success_o); end
    ncmp++; if (err_cnt_o !== 4'd1) begin nerr++; $display("FAIL t1_cnt: got %0d want 1", err_cnt_o); end
    ncmp++; if (err_vec_o !== ev) begin nerr++; $display("FAIL t1_vec: got %0h want %0h", err_vec_o, ev); end
    ncmp++; if (elat !== 3) begin nerr++; $display("FAIL t1_early_latency: got %0d want 3", elat); end
    ncmp++; if (es_success !== 1'b1) begin nerr++; $display("FAIL t1_early_success: got %b want 1", es_success); end
    ncmp++; if (es_vec !== ev) begin nerr++; $display("FAIL t1_early_vec: got %0h want %0h", es_vec, ev); end
  endtask

  task automatic test_two_roots;
    run(10'd63, 4'd2, 4'd6, 4'd2, pk(10'h001, 10'h020, 10'h021), 1'b1, 1'b0, lat, elat);
    ev = bits(0, 62);
    ncmp++; if (lat !== 10) begin nerr++; $display("FAIL t2_latency: got %0d want 10", lat); end
    ncmp++; if (success_o !== 1'b1) begin nerr++; $display("FAIL t2_success: got %b want 1", success_o); end
    ncmp++; if (err_cnt_o !== 4'd2) begin nerr++; $display("FAIL t2_cnt: got %0d want 2", err_cnt_o); end
    ncmp++; if (err_vec_o !== ev) begin nerr++; $display("FAIL t2_vec: got %0h want %0h", err_vec_o, ev); end
    ncmp++; if (es_vec !== ev) begin nerr++; $display("FAIL t2_early_vec: got %0h want %0h", es_vec, ev); end
  endtask

  task automatic test_wrong_degree;
    run(10'd63, 4'd2, 4'd6, 4'd2, pk(10'h001, 10'h020, 10'h000), 1'b0, 1'b0, lat, elat);
    ev = bits(5, -1);
    ncmp++; if (lat !== 10) begin nerr++; $display("FAIL t3_latency: got %0d want 10", lat); end
    ncmp++; if (success_o !== 1'b0) begin nerr++; $display("FAIL t3_success: got %b want 0", success_o); end
    ncmp++; if (err_cnt_o !== 4'd1) begin nerr++; $display("FAIL t3_cnt: got %0d want 1", err_cnt_o); end
    ncmp++; if (err_vec_o !== ev) begin nerr++; $display("FAIL t3_vec: got %0h want %0h", err_vec_o, ev); end
    run(10'd63, 4'd2, 4'd6, 4'd1, pk(10'h3C1, 10'h3E0, 10'h000), 1'b0, 1'b0, lat, elat);
    ncmp++; if (success_o !== 1'b1) begin nerr++; $display("FAIL high_bits_success: got %b want 1", success_o); end
    ncmp++; if (err_vec_o !== ev) begin nerr++; $display("FAIL high_bits_vec: got %0h want %0h", err_vec_o, ev); end
  endtask

  task automatic test_cfg;
    run(10'd63, 4'd2, 4'd6, 4'd3, pk(10'h001, 10'h020, 10'h021), 1'b0, 1'b0, lat, elat);
    ncmp++; if (lat !== 2) begin nerr++; $display("FAIL t4_deg_latency: got %0d want 2", lat); end
    ncmp++; if (success_o !== 1'b0) begin nerr++; $display("FAIL t4_deg_success: got %b want 0", success_o); end
    ncmp++; if (err_vec_o !== '0) begin nerr++; $display("FAIL t4_deg_vec: nonzero error vector"); end
    run(10'd64, 4'd2, 4'd6, 4'd1, pk(10'h001, 10'h020, 10'h000), 1'b0, 1'b0, lat, elat);
    ncmp++; if (lat !== 2) begin nerr++; $display("FAIL t4_n64_latency: got %0d want 2", lat); end
    ncmp++; if (success_o !== 1'b0) begin nerr++; $display("FAIL t4_n64_success: got %b want 0", success_o); end
    ncmp++; if (err_vec_o !== '0) begin nerr++; $display("FAIL t4_n64_vec: nonzero error vector"); end
    run(10'd63, 4'd2, 4'd6, 4'd0, pk(10'h001, 10'h000, 10'h000), 1'b0, 1'b0, lat, elat);
    ncmp++; if (lat !== 2) begin nerr++; $display("FAIL deg0_latency: got %0d want 2", lat); end
    ncmp++; if (success_o !== 1'b1) begin nerr++; $display("FAIL deg0_success: got %b want 1", success_o); end
    run(10'd63, 4'd2, 4'd6, 4'd1, pk(10'h000, 10'h020, 10'h000), 1'b0, 1'b0, lat, elat);
    ncmp++; if (success_o !== 1'b0) begin nerr++; $display("FAIL sigma0_zero_success: got %b want 0", success_o); end
    run(10'd63, 4'd2, 4'd7, 4'd1, pk(10'h001, 10'h020, 10'h000), 1'b0, 1'b0, lat, elat);
    ncmp++; if (lat !== 2) begin nerr++; $display("FAIL bad_m_latency: got %0d want 2", lat); end
    ncmp++; if (success_o !== 1'b0) begin nerr++; $display("FAIL bad_m_success: got %b want 0", success_o); end
  endtask

  task automatic test_fields;
    run(10'd255, 4'd4, 4'd8, 4'd1, pk(10'h001, 10'h08E, 10'h000), 1'b0, 1'b0, lat, elat);
    ev = bits(254, -1);
    ncmp++; if (lat !== 34) begin nerr++; $display("FAIL t5_latency: got %0d want 34", lat); end
    ncmp++; if (elat !== 34) begin nerr++; $display("FAIL t5_early_latency: got %0d want 34", elat); end
    ncmp++; if (success_o !== 1'b1) begin nerr++; $display("FAIL t5_success: got %b want 1", success_o); end
    ncmp++; if (err_vec_o !== ev) begin nerr++; $display("FAIL t5_vec: got %0h want %0h", err_vec_o, ev); end
    run(10'd100, 4'd4, 4'd8, 4'd1, pk(10'h001, 10'h08E, 10'h000), 1'b0, 1'b0, lat, elat);
    ncmp++; if (lat !== 15) begin nerr++; $display("FAIL t5_short_latency: got %0d want 15", lat); end
    ncmp++; if (success_o !== 1'b0) begin nerr++; $display("FAIL t5_short_success: got %b want 0", success_o); end
    ncmp++; if (err_cnt_o !== 4'd0) begin nerr++; $display("FAIL t5_short_cnt: got %0d want 0", err_cnt_o); end
    ncmp++; if (err_vec_o !== '0) begin nerr++; $display("FAIL t5_short_vec: nonzero error vector"); end
    run(10'd1023, 4'd4, 4'd10, 4'd1, pk(10'h001, 10'h204, 10'h000), 1'b0, 1'b0, lat, elat);
    ev = bits(1022, -1);
    ncmp++; if (lat !== 130) begin nerr++; $display("FAIL m10_latency: got %0d want 130", lat); end
    ncmp++; if (success_o !== 1'b1) begin nerr++; $display("FAIL m10_success: got %b want 1", success_o); end
    ncmp++; if (err_vec_o !== ev) begin nerr++; $display("FAIL m10_vec: got %0h want %0h", err_vec_o, ev); end
  endtask

  task automatic test_reset_mid;
    bit saw_done;
    @(negedge clk);
    n_i = 10'd63; t_i = 4'd2; m_i = 4'd6; sigma_deg_i = 4'd2; sigma_i = pk(10'h001, 10'h020, 10'h021);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    ncmp++; if (busy_o !== 1'b1) begin nerr++; $display("FAIL t6_busy_before: got %b want 1", busy_o); end
    ncmp++; if (err_cnt_o !== 4'd1) begin nerr++; $display("FAIL t6_cnt_before: got %0d want 1", err_cnt_o); end
    rst_n = 1'b0;
    #1;
    ncmp++; if (busy_o !== 1'b0) begin nerr++; $display("FAIL t6_busy: got %b want 0", busy_o); end
    ncmp++; if (err_cnt_o !== 4'd0) begin nerr++; $display("FAIL t6_cnt: got %0d want 0", err_cnt_o); end
    ncmp++; if (err_vec_o !== '0) begin nerr++; $display("FAIL t6_vec: nonzero error vector"); end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done_o) saw_done = 1'b1;
    end
    ncmp++; if (saw_done !== 1'b0) begin nerr++; $display("FAIL t6_no_done: got %b want 0", saw_done); end
  endtask

  task automatic test_back_to_back;
    run(10'd63, 4'd2, 4'd6, 4'd1, pk(10'h001, 10'h020, 10'h000), 1'b0, 1'b1, lat, elat);
    ev = bits(5, -1);
    ncmp++; if (lat !== 10) begin nerr++; $display("FAIL b2b_latency: got %0d want 10", lat); end
    ncmp++; if (success_o !== 1'b1) begin nerr++; $display("FAIL b2b_success: got %b want 1", success_o); end
    ncmp++; if (err_vec_o !== ev) begin nerr++; $display("FAIL b2b_vec: got %0h want %0h", err_vec_o, ev); end
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    ncmp++; if (busy_o !== 1'b0) begin nerr++; $display("FAIL done_cycle_start: got busy %b want 0", busy_o); end
    ncmp++; if (success_o !== 1'b1) begin nerr++; $display("FAIL hold_success: got %b want 1", success_o); end
    ncmp++; if (err_vec_o !== ev) begin nerr++; $display("FAIL hold_vec: got %0h want %0h", err_vec_o, ev); end
    run(10'd63, 4'd2, 4'd6, 4'd2, pk(10'h001, 10'h020, 10'h021), 1'b0, 1'b0, lat, elat);
    ncmp++; if (err_cnt_o !== 4'd2) begin nerr++; $display("FAIL b2b_second_cnt: got %0d want 2", err_cnt_o); end
    ncmp++; if (err_vec_o !== bits(0, 62)) begin nerr++; $display("FAIL b2b_second_vec: got %0h", err_vec_o); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_two_roots;
    test_wrong_degree;
    test_cfg;
    test_fields;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
